// File: rtl/lcd_dfa_ram_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ write requesters onto one RAM write port.
// Optional post-reset RAM clear sweep is compiled in with `define LCD_DFA_ARB_CLEAR_EN.
module lcd_dfa_ram_wr_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8,
   localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int GID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_writedata,
   output logic [NUM_REQ-1:0]            req_waitrequest,
   output logic [ADDR_WIDTH-1:0]         ram_wr_address,
   output logic [DATA_WIDTH-1:0]         ram_wr_writedata,
   output logic                          ram_wr_write,
   input  logic                          ram_wr_waitrequest,
   output logic [GID_WIDTH-1:0]          grant_id,
   output logic                          init_done
);

   logic                  arb_active_s;
   logic                  grant_vld_s;
   logic [GID_WIDTH-1:0]  grant_idx_s;
   logic                  accept_s;
   logic [GID_WIDTH-1:0]  rr_ptr_q;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [GID_WIDTH-1:0]  gid_q;

   // Circular search for the first active requester starting at rr_ptr
   always_comb begin
      int idx;
      idx         = 0;
      grant_vld_s = 1'b0;
      grant_idx_s = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end else begin
            idx = idx;
         end
         if (!grant_vld_s && req_write[idx]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = GID_WIDTH'(idx);
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   assign accept_s = arb_active_s && !ram_wr_waitrequest && grant_vld_s;

   // Only the accepted requester sees its stall released in this cycle
   always_comb begin
      if (accept_s) begin
         req_waitrequest = ~(NUM_REQ'(1) << grant_idx_s);
      end else begin
         req_waitrequest = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         gid_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         wr_q <= accept_s;
         if (accept_s) begin
            addr_q <= req_address[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
            data_q <= req_writedata[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
            gid_q  <= grant_idx_s;
            if (grant_idx_s == GID_WIDTH'(NUM_REQ-1)) begin
               rr_ptr_q <= '0;
            end else begin
               rr_ptr_q <= grant_idx_s + GID_WIDTH'(1);
            end
         end else begin
            addr_q   <= addr_q;
            data_q   <= data_q;
            gid_q    <= gid_q;
            rr_ptr_q <= rr_ptr_q;
         end
      end
   end

   assign grant_id = gid_q;

`ifdef LCD_DFA_ARB_CLEAR_EN
   typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_ARB = 1'b1} state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;
   logic                  in_clear_s;

   // Zero-fill sweep over every RAM word, advancing only when the RAM accepts
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (!ram_wr_waitrequest) begin
                  if (clr_cnt_q == ADDR_WIDTH'(DEPTH-1)) begin
                     state_q   <= ST_ARB;
                     clr_cnt_q <= clr_cnt_q;
                  end else begin
                     state_q   <= ST_CLEAR;
                     clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                  end
               end else begin
                  state_q   <= ST_CLEAR;
                  clr_cnt_q <= clr_cnt_q;
               end
            end
            ST_ARB: begin
               state_q   <= ST_ARB;
               clr_cnt_q <= clr_cnt_q;
            end
            default: begin
               state_q   <= ST_ARB;
               clr_cnt_q <= '0;
            end
         endcase
      end
   end

   assign in_clear_s       = (state_q == ST_CLEAR) && !reset;
   assign arb_active_s     = (state_q == ST_ARB) && !reset;
   assign init_done        = arb_active_s;
   assign ram_wr_write     = in_clear_s || (wr_q && !reset);
   assign ram_wr_address   = in_clear_s ? clr_cnt_q : addr_q;
   assign ram_wr_writedata = in_clear_s ? {DATA_WIDTH{1'b0}} : data_q;
`else
   logic arb_q;

   // Arbitration opens on the first cycle after reset is released
   always_ff @(posedge clk) begin
      if (reset) begin
         arb_q <= 1'b0;
      end else begin
         arb_q <= 1'b1;
      end
   end

   assign arb_active_s     = arb_q && !reset;
   assign init_done        = arb_active_s;
   assign ram_wr_write     = wr_q && !reset;
   assign ram_wr_address   = addr_q;
   assign ram_wr_writedata = data_q;
`endif

endmodule

// File: tb/tb_lcd_dfa_ram_wr_arbiter.sv
// Directed bench for lcd_dfa_ram_wr_arbiter with a write scoreboard and round-robin model.
module tb_lcd_dfa_ram_wr_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_write;
   logic [11:0] req_address;
   logic [23:0] req_writedata;
   logic [2:0]  req_waitrequest;
   logic [3:0]  ram_wr_address;
   logic [7:0]  ram_wr_writedata;
   logic        ram_wr_write;
   logic        ram_wr_waitrequest;
   logic [1:0]  grant_id;
   logic        init_done;

   int tests = 0;
   int fails = 0;
   int rr_m  = 0;
   bit act_m = 1'b0;
   logic [13:0] sb[$];

   lcd_dfa_ram_wr_arbiter #(.NUM_REQ(3), .DEPTH(16), .DATA_WIDTH(8)) dut (
      .clk                (clk),
      .reset              (reset),
      .req_write          (req_write),
      .req_address        (req_address),
      .req_writedata      (req_writedata),
      .req_waitrequest    (req_waitrequest),
      .ram_wr_address     (ram_wr_address),
      .ram_wr_writedata   (ram_wr_writedata),
      .ram_wr_write       (ram_wr_write),
      .ram_wr_waitrequest (ram_wr_waitrequest),
      .grant_id           (grant_id),
      .init_done          (init_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] a, input logic [7:0] d);
      req_address[i*4 +: 4]   = a;
      req_writedata[i*8 +: 8] = d;
   endtask

   // One clock: drive, predict with the model, check stall, then check the issued write
   task automatic cyc(input logic r, input logic [2:0] w, input logic wt);
      logic        exp_wr;
      logic [2:0]  exp_wq;
      logic [13:0] item;
      int          g;
      int          idx;
      reset              = r;
      req_write          = w;
      ram_wr_waitrequest = wt;
      exp_wr = 1'b0;
      exp_wq = 3'b111;
      g      = -1;
      if (act_m && !r && !wt) begin
         for (int k = 0; k < 3; k++) begin
            idx = (rr_m + k) % 3;
            if (g < 0 && w[idx]) g = idx;
         end
      end
      if (g >= 0) begin
         exp_wr    = 1'b1;
         exp_wq[g] = 1'b0;
         sb.push_back({2'(g), req_address[g*4 +: 4], req_writedata[g*8 +: 8]});
         rr_m = (g + 1) % 3;
      end
      if (r) rr_m = 0;
      #1;
      chk("req_waitrequest", 32'(req_waitrequest), 32'(exp_wq));
      @(posedge clk);
      #1;
      act_m = !r;
      chk("ram_wr_write", 32'(ram_wr_write), 32'(exp_wr));
      chk("init_done", 32'(init_done), 32'(act_m));
      if (exp_wr) begin
         item = sb.pop_front();
         chk("grant_id", 32'(grant_id), 32'(item[13:12]));
         chk("ram_wr_address", 32'(ram_wr_address), 32'(item[11:8]));
         chk("ram_wr_writedata", 32'(ram_wr_writedata), 32'(item[7:0]));
      end
   endtask

   initial begin
      reset              = 1'b1;
      req_write          = 3'b000;
      req_address        = 12'h000;
      req_writedata      = 24'h000000;
      ram_wr_waitrequest = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ram_wr_write", 32'(ram_wr_write), 32'd0);
      chk("rst_ram_wr_address", 32'(ram_wr_address), 32'd0);
      chk("rst_ram_wr_writedata", 32'(ram_wr_writedata), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_req_waitrequest", 32'(req_waitrequest), 32'h7);
      chk("rst_init_done", 32'(init_done), 32'd0);

`ifdef LCD_DFA_ARB_CLEAR_EN
      reset     = 1'b0;
      req_write = 3'b111;
      for (int a = 0; a < 8; a++) begin
         chk("clr_write", 32'(ram_wr_write), 32'd1);
         chk("clr_addr", 32'(ram_wr_address), 32'(a));
         chk("clr_wait", 32'(req_waitrequest), 32'h7);
         if (a < 7) begin
            @(posedge clk);
            #1;
         end
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int a = 0; a < 16; a++) begin
         chk("clr_write", 32'(ram_wr_write), 32'd1);
         chk("clr_addr", 32'(ram_wr_address), 32'(a));
         chk("clr_data", 32'(ram_wr_writedata), 32'd0);
         chk("clr_wait", 32'(req_waitrequest), 32'h7);
         chk("clr_init_done", 32'(init_done), 32'd0);
         @(posedge clk);
         #1;
      end
      req_write = 3'b000;
      chk("clr_done_init", 32'(init_done), 32'd1);
      chk("clr_done_write", 32'(ram_wr_write), 32'd0);
      act_m = 1'b1;
      rr_m  = 0;
`else
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_init_done", 32'(init_done), 32'd1);
      chk("rel_ram_wr_write", 32'(ram_wr_write), 32'd0);
      chk("rel_req_waitrequest", 32'(req_waitrequest), 32'h7);
      act_m = 1'b1;
`endif
      cyc(1'b0, 3'b000, 1'b0);

      // Three requesters held: expect 0,1,2,0,1,2
      set_req(0, 4'd1, 8'h11);
      set_req(1, 4'd2, 8'h22);
      set_req(2, 4'd3, 8'h33);
      repeat (6) cyc(1'b0, 3'b111, 1'b0);

      set_req(1, 4'd5, 8'hA5);
      cyc(1'b0, 3'b010, 1'b0);

      // RAM stall for 4 cycles, then accept on release
      set_req(1, 4'd9, 8'h5C);
      repeat (4) cyc(1'b0, 3'b010, 1'b1);
      cyc(1'b0, 3'b010, 1'b0);
      cyc(1'b0, 3'b111, 1'b0);

      // Withdrawn requester produces no write
      cyc(1'b0, 3'b001, 1'b1);
      cyc(1'b0, 3'b000, 1'b0);

      // Lone requester gets every cycle
      set_req(2, 4'd14, 8'hE7);
      repeat (3) cyc(1'b0, 3'b100, 1'b0);
      set_req(2, 4'd15, 8'hF0);
      cyc(1'b0, 3'b100, 1'b0);

`ifndef LCD_DFA_ARB_CLEAR_EN
      // Reset mid-traffic drops pending work and restarts the pointer
      cyc(1'b0, 3'b111, 1'b0);
      cyc(1'b1, 3'b111, 1'b0);
      cyc(1'b0, 3'b111, 1'b0);
      cyc(1'b0, 3'b111, 1'b0);
      cyc(1'b0, 3'b110, 1'b0);
`endif
      cyc(1'b0, 3'b000, 1'b0);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
